// File: rtl/mdio_phy_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mdio_phy_responder
//   Clause-22 MDIO management slave that emulates a small PHY register file.
//   It runs on clk_clk, oversamples the MAC's MDC, decodes read and write
//   frames, answers reads on MDIO and reports every accepted write.
//
//   Ports:
//     clk_clk        system clock (>= 8x MDC)
//     reset_reset_n  asynchronous active-low reset
//     mdc            MDIO clock from the MAC (asynchronous)
//     mdio_in        resolved MDIO line level
//     mdio_out       value driven onto MDIO
//     mdio_oen       output enable, active low
//     link_up        live link state, returned in reg1[2]
//     reg_wr_valid   one-cycle pulse per accepted write
//     reg_wr_addr    register address of the last accepted write
//     reg_wr_data    data of the last accepted write
//
//   Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN
//     When defined, once a frame addressed to PHY_ADDR has completed, a
//     start-of-frame is accepted with no preamble until the next reset.
// ----------------------------------------------------------------------------
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter int          PRE_LEN     = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] PHY_ID1     = 16'h0141,
    parameter logic [15:0] PHY_ID2     = 16'h0CC2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic        reg_wr_valid,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_OP, ST_PHYAD, ST_REGAD, ST_TA, ST_DATA
    } state_t;

    // Power-on / soft-reset value of each implemented register.
    function automatic logic [15:0] reg_default(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'h1140;
            4'd1:    val = 16'h7969;
            4'd2:    val = PHY_ID1;
            4'd3:    val = PHY_ID2;
            default: val = 16'h0000;
        endcase
        return val;
    endfunction

    logic [SYNC_STAGES-1:0] mdc_sync_r;
    logic [SYNC_STAGES-1:0] mdio_sync_r;
    logic                   mdc_d_r;
    logic                   rise_s;
    logic                   fall_s;
    logic                   bit_s;

    state_t      state_r, state_nx_s;
    logic [3:0]  bit_cnt_r, bit_cnt_nx_s;
    logic [5:0]  pre_cnt_r, pre_cnt_nx_s;
    logic        frame_done_s;
    logic        suppress_ok_s;

    logic [14:0] shift_r;
    logic        is_read_r;
    logic        phy_match_r;
    logic [4:0]  regad_r;
    logic [15:0] rd_shift_r;
    logic [15:0] rd_word_s;
    logic [15:0] wr_data_s;
    logic        wr_fire_s;
    logic        writable_s;
    logic        soft_rst_r;

    logic [15:0] reg_file_r [0:15];

    logic        mdio_out_r;
    logic        mdio_oen_r;
    logic        reg_wr_valid_r;
    logic [4:0]  reg_wr_addr_r;
    logic [15:0] reg_wr_data_r;

    assign rise_s = mdc_sync_r[SYNC_STAGES-1] & ~mdc_d_r;
    assign fall_s = ~mdc_sync_r[SYNC_STAGES-1] & mdc_d_r;
    assign bit_s  = mdio_sync_r[SYNC_STAGES-1];

    // Synchronizers for the asynchronous MDC/MDIO plus MDC edge history.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mdc_sync_r  <= '0;
            mdio_sync_r <= '1;
            mdc_d_r     <= 1'b0;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[SYNC_STAGES-2:0], mdc};
            mdio_sync_r <= {mdio_sync_r[SYNC_STAGES-2:0], mdio_in};
            mdc_d_r     <= mdc_sync_r[SYNC_STAGES-1];
        end
    end

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic pre_ok_r;

    // Preamble-suppression privilege, earned by one completed matched frame.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_ok_r <= 1'b0;
        end else if (frame_done_s && phy_match_r) begin
            pre_ok_r <= 1'b1;
        end
    end

    assign suppress_ok_s = pre_ok_r;
`else
    assign suppress_ok_s = 1'b0;
`endif

    // FSM state, bit counter and preamble counter registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            pre_cnt_r <= 6'd0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            pre_cnt_r <= pre_cnt_nx_s;
        end
    end

    // Frame decoder: advances only on a synchronized MDC rise.
    always_comb begin
        state_nx_s   = state_r;
        bit_cnt_nx_s = bit_cnt_r;
        pre_cnt_nx_s = pre_cnt_r;
        frame_done_s = 1'b0;
        if (rise_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (bit_s) begin
                        pre_cnt_nx_s = (pre_cnt_r == 6'(PRE_LEN)) ? pre_cnt_r : pre_cnt_r + 6'd1;
                    end else begin
                        pre_cnt_nx_s = 6'd0;
                        state_nx_s   = ((pre_cnt_r == 6'(PRE_LEN)) || suppress_ok_s) ? ST_START : ST_IDLE;
                    end
                end
                ST_START: begin
                    bit_cnt_nx_s = 4'd0;
                    state_nx_s   = bit_s ? ST_OP : ST_IDLE;
                end
                ST_OP: begin
                    if (bit_cnt_r == 4'd0) begin
                        bit_cnt_nx_s = 4'd1;
                    end else begin
                        bit_cnt_nx_s = 4'd0;
                        // shift_r[0] holds the first opcode bit: 10 = read, 01 = write
                        state_nx_s   = (shift_r[0] != bit_s) ? ST_PHYAD : ST_IDLE;
                    end
                end
                ST_PHYAD, ST_REGAD: begin
                    if (bit_cnt_r == 4'd4) begin
                        bit_cnt_nx_s = 4'd0;
                        state_nx_s   = (state_r == ST_PHYAD) ? ST_REGAD : ST_TA;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end
                end
                ST_TA: begin
                    if (bit_cnt_r == 4'd1) begin
                        bit_cnt_nx_s = 4'd0;
                        state_nx_s   = ST_DATA;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 4'd15) begin
                        bit_cnt_nx_s = 4'd0;
                        frame_done_s = 1'b1;
                        state_nx_s   = ST_IDLE;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    bit_cnt_nx_s = 4'd0;
                    state_nx_s   = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    assign wr_data_s  = {shift_r, bit_s};
    assign wr_fire_s  = rise_s && (state_r == ST_DATA) && (bit_cnt_r == 4'd15)
                        && !is_read_r && phy_match_r;
    // r1..r3 and the unimplemented upper half are read-only
    assign writable_s = !regad_r[4] && (regad_r[3:0] != 4'd1)
                        && (regad_r[3:0] != 4'd2) && (regad_r[3:0] != 4'd3);

    // Read data selection; reg1[2] always reflects the live link state.
    always_comb begin
        rd_word_s = 16'h0000;
        if (regad_r[4]) begin
            rd_word_s = 16'h0000;
        end else begin
            rd_word_s    = reg_file_r[regad_r[3:0]];
            rd_word_s[2] = (regad_r[3:0] == 4'd1) ? link_up : reg_file_r[regad_r[3:0]][2];
        end
    end

    // Frame field capture: opcode, PHY address match, register address, data.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shift_r     <= 15'd0;
            is_read_r   <= 1'b0;
            phy_match_r <= 1'b0;
            regad_r     <= 5'd0;
        end else if (rise_s) begin
            if ((state_r == ST_OP) || (state_r == ST_PHYAD) ||
                (state_r == ST_REGAD) || (state_r == ST_DATA)) begin
                shift_r <= {shift_r[13:0], bit_s};
            end
            if ((state_r == ST_OP) && (bit_cnt_r == 4'd1)) begin
                is_read_r <= shift_r[0] & ~bit_s;
            end
            if ((state_r == ST_PHYAD) && (bit_cnt_r == 4'd4)) begin
                phy_match_r <= ({shift_r[3:0], bit_s} == PHY_ADDR);
            end
            if ((state_r == ST_REGAD) && (bit_cnt_r == 4'd4)) begin
                regad_r <= {shift_r[3:0], bit_s};
            end
        end
    end

    // Register file with write-back and the r0[15] self-clearing soft reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 16; i++) begin
                reg_file_r[i] <= reg_default(4'(i));
            end
            soft_rst_r <= 1'b0;
        end else begin
            soft_rst_r <= wr_fire_s && (regad_r == 5'd0) && wr_data_s[15];
            if (soft_rst_r) begin
                for (int i = 0; i < 16; i++) begin
                    reg_file_r[i] <= reg_default(4'(i));
                end
            end else if (wr_fire_s && writable_s) begin
                reg_file_r[regad_r[3:0]] <= (regad_r[3:0] == 4'd0) ?
                                            {1'b0, wr_data_s[14:0]} : wr_data_s;
            end
        end
    end

    // Write report: pulse on every matched write, address/data held afterwards.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            reg_wr_valid_r <= 1'b0;
            reg_wr_addr_r  <= 5'd0;
            reg_wr_data_r  <= 16'h0000;
        end else begin
            reg_wr_valid_r <= wr_fire_s;
            if (wr_fire_s) begin
                reg_wr_addr_r <= regad_r;
                reg_wr_data_r <= wr_data_s;
            end
        end
    end

    // MDIO driver, updated on synchronized MDC falls during a matched read.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mdio_out_r <= 1'b1;
            mdio_oen_r <= 1'b1;
            rd_shift_r <= 16'h0000;
        end else if (fall_s) begin
            if (is_read_r && phy_match_r && (state_r == ST_TA) && (bit_cnt_r == 4'd0)) begin
                // first TA bit stays Z; snapshot the read word (and link_up) here
                mdio_out_r <= 1'b1;
                mdio_oen_r <= 1'b1;
                rd_shift_r <= rd_word_s;
            end else if (is_read_r && phy_match_r && (state_r == ST_TA)) begin
                mdio_out_r <= 1'b0;
                mdio_oen_r <= 1'b0;
            end else if (is_read_r && phy_match_r && (state_r == ST_DATA)) begin
                mdio_out_r <= rd_shift_r[15];
                mdio_oen_r <= 1'b0;
                rd_shift_r <= {rd_shift_r[14:0], 1'b0};
            end else begin
                mdio_out_r <= 1'b1;
                mdio_oen_r <= 1'b1;
            end
        end
    end

    assign mdio_out     = mdio_out_r;
    assign mdio_oen     = mdio_oen_r;
    assign reg_wr_valid = reg_wr_valid_r;
    assign reg_wr_addr  = reg_wr_addr_r;
    assign reg_wr_data  = reg_wr_data_r;

endmodule

// File: tb/tb_mdio_phy_responder.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_mdio_phy_responder
//   Drives MDIO frames as a MAC master would and checks the responder through
//   a scoreboard: stimulus queues expected read words and write reports, and
//   independent monitors pop and compare when the DUT drives data or pulses
//   reg_wr_valid.
// ----------------------------------------------------------------------------
module tb_mdio_phy_responder;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        mdc           = 1'b0;
    logic        link_up       = 1'b0;
    logic        master_oe     = 1'b1;
    logic        master_bit    = 1'b1;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic        reg_wr_valid;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;

    int tests = 0;
    int fails = 0;
    int wr_seen = 0;
    bit oen_low_seen = 1'b0;

    logic [15:0] exp_rd_q [$];
    logic [20:0] exp_wr_q [$];

    // Resolved line: master, else responder, else pull-up.
    assign mdio_in = master_oe ? master_bit : (mdio_oen ? 1'b1 : mdio_out);

    mdio_phy_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .mdc           (mdc),
        .mdio_in       (mdio_in),
        .mdio_out      (mdio_out),
        .mdio_oen      (mdio_oen),
        .link_up       (link_up),
        .reg_wr_valid  (reg_wr_valid),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One MDC period; the master changes data right after the falling edge.
    task automatic mbit(input logic b, input logic oe);
        master_oe  = oe;
        master_bit = b;
        #80 mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic frame(input int pre, input logic rd, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd);
        for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1);
        mbit(1'b0, 1'b1);
        mbit(1'b1, 1'b1);
        mbit(rd, 1'b1);
        mbit(~rd, 1'b1);
        for (int i = 4; i >= 0; i--) mbit(pa[i], 1'b1);
        for (int i = 4; i >= 0; i--) mbit(ra[i], 1'b1);
        if (rd) begin
            master_oe = 1'b0;
            #80;
            check("ta1_released", {31'd0, mdio_oen}, 32'd1);
            mdc = 1'b1;
            #80 mdc = 1'b0;
            for (int i = 0; i < 17; i++) mbit(1'b1, 1'b0);
        end else begin
            mbit(1'b1, 1'b1);
            mbit(1'b0, 1'b1);
            for (int i = 15; i >= 0; i--) mbit(wd[i], 1'b1);
        end
        mbit(1'b1, 1'b0);
        mbit(1'b1, 1'b0);
    endtask

    task automatic do_read(input logic [4:0] ra, input logic [15:0] exp);
        exp_rd_q.push_back(exp);
        frame(32, 1'b1, 5'd0, ra, 16'h0000);
    endtask

    task automatic do_write(input logic [4:0] ra, input logic [15:0] wd);
        exp_wr_q.push_back({ra, wd});
        frame(32, 1'b0, 5'd0, ra, wd);
    endtask

    // A frame that must produce neither MDIO drive nor a write report.
    task automatic ignored_frame(input string name, input int pre, input logic rd,
                                 input logic [4:0] pa, input logic [4:0] ra);
        int wr0;
        wr0 = wr_seen;
        oen_low_seen = 1'b0;
        frame(pre, rd, pa, ra, 16'h5555);
        check({name, "_no_drive"}, {31'd0, oen_low_seen}, 32'd0);
        check({name, "_no_write"}, wr_seen - wr0, 32'd0);
    endtask

    // Record any cycle in which the responder enables its driver.
    always @(negedge clk_clk) begin
        if (mdio_oen === 1'b0) oen_low_seen = 1'b1;
    end

    // Write monitor: every reg_wr_valid pulse consumes one expected write.
    always @(negedge clk_clk) begin
        logic [20:0] e;
        if (reg_wr_valid === 1'b1) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                         reg_wr_addr, reg_wr_data);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", {27'd0, reg_wr_addr}, {27'd0, e[20:16]});
                check("wr_data", {16'd0, reg_wr_data}, {16'd0, e[15:0]});
            end
        end
    end

    // Read monitor: collects TA bit 2 and 16 data bits whenever the DUT drives.
    initial begin
        logic [15:0] d;
        logic [15:0] e;
        forever begin
            @(negedge mdio_oen);
            @(posedge mdc);
            check("ta2_zero", {31'd0, mdio_in}, 32'd0);
            d = 16'h0000;
            for (int i = 0; i < 16; i++) begin
                @(posedge mdc);
                d = {d[14:0], mdio_in};
            end
            if (exp_rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got %h, expected no read", d);
            end else begin
                e = exp_rd_q.pop_front();
                check("rd_data", {16'd0, d}, {16'd0, e});
            end
            @(negedge mdc);
            repeat (8) @(negedge clk_clk);
            check("release_after_d0", {31'd0, mdio_oen}, 32'd1);
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #52;
        check("rst_mdio_out", {31'd0, mdio_out}, 32'd1);
        check("rst_mdio_oen", {31'd0, mdio_oen}, 32'd1);
        check("rst_wr_valid", {31'd0, reg_wr_valid}, 32'd0);
        check("rst_wr_addr", {27'd0, reg_wr_addr}, 32'd0);
        check("rst_wr_data", {16'd0, reg_wr_data}, 32'd0);
        #48 reset_reset_n = 1'b1;
        #200;

        do_read(5'd2, 16'h0141);
        do_write(5'd4, 16'hA5C3);
        do_read(5'd4, 16'hA5C3);

        // read-only register: reported but not stored
        do_write(5'd2, 16'hFFFF);
        do_read(5'd2, 16'h0141);

        ignored_frame("mismatch_rd", 32, 1'b1, 5'd7, 5'd0);
        ignored_frame("mismatch_wr", 32, 1'b0, 5'd7, 5'd4);
        do_read(5'd4, 16'hA5C3);

        link_up = 1'b1;
        do_read(5'd1, 16'h796D);
        link_up = 1'b0;
        do_read(5'd1, 16'h7969);

        do_read(5'd20, 16'h0000);
        do_write(5'd15, 16'h0F0F);
        do_read(5'd15, 16'h0F0F);

        do_write(5'd4, 16'h1234);
        do_read(5'd4, 16'h1234);
        do_write(5'd0, 16'h8000);
        do_read(5'd4, 16'h0000);
        do_read(5'd0, 16'h1140);
        do_read(5'd15, 16'h0000);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        exp_rd_q.push_back(16'h0CC2);
        frame(0, 1'b1, 5'd0, 5'd3, 16'h0000);
`else
        mbit(1'b0, 1'b1);
        ignored_frame("short_preamble", 31, 1'b1, 5'd0, 5'd2);
        mbit(1'b0, 1'b1);
        do_read(5'd3, 16'h0CC2);
`endif

        repeat (4) mbit(1'b1, 1'b0);
        check("rd_queue_empty", exp_rd_q.size(), 32'd0);
        check("wr_queue_empty", exp_wr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
